// File: rtl/line_mem_pkg.sv
// Shared types, default geometry and fill pattern for the line-granular backing memory.
package line_mem_pkg;

  localparam int unsigned DEF_LINE_ADDR_LEN = 3;
  localparam int unsigned DEF_ADDR_LEN      = 7;
  localparam int unsigned DEF_LATENCY       = 4;
  localparam int unsigned LINE_SIZE         = 1 << DEF_LINE_ADDR_LEN;
  localparam int unsigned CNT_W             = 8;

  typedef enum logic [1:0] {INIT, IDLE, BUSY, GRANT} state_e;

  // Word k of line a after INIT: the flat word index, zero-extended.
  function automatic logic [31:0] init_word(input int unsigned a,
                                            input int unsigned k,
                                            input int unsigned line_addr_len = DEF_LINE_ADDR_LEN);
    return 32'((a << line_addr_len) | k);
  endfunction

endpackage

// File: rtl/line_mem_array.sv
// Line storage: one synchronous whole-line write port and one registered whole-line read port.
module line_mem_array #(
  parameter int unsigned ADDR_LEN = 7,
  parameter int unsigned WORDS    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_LEN-1:0] waddr,
  input  logic [31:0]         wdata [WORDS],
  input  logic                re,
  input  logic [ADDR_LEN-1:0] raddr,
  output logic [31:0]         rdata [WORDS]
);

  localparam int unsigned DEPTH = 1 << ADDR_LEN;

  logic [31:0] mem_q   [DEPTH][WORDS];
  logic [31:0] rdata_q [WORDS];
  logic [31:0] rdata_d [WORDS];

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned k = 0; k < WORDS; k++) begin
        mem_q[waddr][k] <= wdata[k];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      for (int unsigned k = 0; k < WORDS; k++) begin
        rdata_d[k] = mem_q[raddr][k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '{default: '0};
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/line_mem_responder.sv
// Responder end of the cache-to-memory line handshake: self-initialising array,
// programmable access latency, one whole line per transaction.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int unsigned LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int unsigned ADDR_LEN      = DEF_ADDR_LEN,
  parameter int unsigned LATENCY       = DEF_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic                rd_req,
  input  logic                wr_req,
  input  logic [31:0]         wr_line [2**LINE_ADDR_LEN],
  output logic                gnt,
  output logic [31:0]         rd_line [2**LINE_ADDR_LEN],
  output logic                busy
);

  localparam int unsigned         WORDS     = 1 << LINE_ADDR_LEN;
  localparam logic [ADDR_LEN-1:0] LAST_LINE = '1;

  state_e              state_q, state_d;
  logic [ADDR_LEN-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_LEN-1:0] cap_addr_q, cap_addr_d;
  logic                cap_wr_q, cap_wr_d;
  logic [31:0]         cap_line_q [WORDS];
  logic [31:0]         cap_line_d [WORDS];

  logic                live;
  logic                arr_we;
  logic                arr_re;
  logic [ADDR_LEN-1:0] arr_waddr;
  logic [31:0]         arr_wdata [WORDS];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    cap_addr_d = cap_addr_q;
    cap_wr_d   = cap_wr_q;
    cap_line_d = cap_line_q;
    arr_we     = 1'b0;
    arr_re     = 1'b0;
    arr_waddr  = ptr_q;
    for (int unsigned k = 0; k < WORDS; k++) begin
      arr_wdata[k] = init_word(32'(ptr_q), k, LINE_ADDR_LEN);
    end
    // The requester must keep the captured op asserted for the whole access.
    live = cap_wr_q ? wr_req : rd_req;

    case (state_q)
      INIT: begin
        arr_we = 1'b1;
        ptr_d  = ptr_q + ADDR_LEN'(1);
        if (ptr_q == LAST_LINE) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        // Writes win over a simultaneous read; the read stays pending.
        if (wr_req || rd_req) begin
          cap_wr_d   = wr_req;
          cap_addr_d = addr;
          cnt_d      = CNT_W'(LATENCY);
          state_d    = BUSY;
          if (wr_req) begin
            cap_line_d = wr_line;
          end
        end
      end
      BUSY: begin
        if (!live) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d   = GRANT;
          arr_waddr = cap_addr_q;
          if (cap_wr_q) begin
            arr_we    = 1'b1;
            arr_wdata = cap_line_q;
          end else begin
            arr_re = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GRANT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
      end
    endcase

    // A reset edge abandons any commit or fill write in flight.
    if (rst) begin
      arr_we = 1'b0;
      arr_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      ptr_q      <= '0;
      cnt_q      <= '0;
      cap_addr_q <= '0;
      cap_wr_q   <= 1'b0;
      cap_line_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      cap_addr_q <= cap_addr_d;
      cap_wr_q   <= cap_wr_d;
      cap_line_q <= cap_line_d;
    end
  end

  line_mem_array #(
    .ADDR_LEN (ADDR_LEN),
    .WORDS    (WORDS)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (cap_addr_q),
    .rdata (rd_line)
  );

  assign gnt  = (state_q == GRANT);
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder at default geometry (8-word lines, 128 lines, latency 4).
module tb_line_mem_responder;
  import line_mem_pkg::*;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic [6:0]  addr   = '0;
  logic [31:0] wr_line [LINE_SIZE];
  logic [31:0] rd_line [LINE_SIZE];
  logic        gnt;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  line_mem_responder dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .rd_req  (rd_req),
    .wr_req  (wr_req),
    .wr_line (wr_line),
    .gnt     (gnt),
    .rd_line (rd_line),
    .busy    (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges from now until gnt is seen high; -1 if it never comes.
  task automatic wait_gnt(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (gnt === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Full transaction from IDLE; returns to IDLE before leaving.
  task automatic txn(input bit wr, input logic [6:0] a, output int cyc);
    addr = a;
    if (wr) wr_req = 1'b1;
    else    rd_req = 1'b1;
    wait_gnt(cyc);
    wr_req = 1'b0;
    rd_req = 1'b0;
    step();
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    for (int k = 0; k < int'(LINE_SIZE); k++) begin
      checks++;
      if (rd_line[k] !== 32'h0) begin
        errors++; $display("FAIL reset_rd_line word %0d: got %h want 0", k, rd_line[k]);
      end
    end
    rst = 1'b0;
    wait_init(n);
    checks++;
    if (n != 128) begin errors++; $display("FAIL init_length: got %0d want 128", n); end
  endtask

  task automatic test_init_read();
    int cyc;
    txn(1'b0, 7'd5, cyc);
    // gnt in the 6th cycle counting the request cycle: 5 edges after drive.
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL rd5_latency: got %0d want 5", cyc); end
    for (int k = 0; k < int'(LINE_SIZE); k++) begin
      checks++;
      if (rd_line[k] !== 32'(40 + k)) begin
        errors++; $display("FAIL rd5 word %0d: got %h want %h", k, rd_line[k], 32'(40 + k));
      end
    end
    txn(1'b0, 7'h7f, cyc);
    for (int k = 0; k < int'(LINE_SIZE); k++) begin
      checks++;
      if (rd_line[k] !== 32'(1016 + k)) begin
        errors++; $display("FAIL rd127 word %0d: got %h want %h", k, rd_line[k], 32'(1016 + k));
      end
    end
  endtask

  task automatic test_write_read();
    int cyc;
    for (int k = 0; k < int'(LINE_SIZE); k++) wr_line[k] = 32'hA000_0000 + 32'(k);
    txn(1'b1, 7'h12, cyc);
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL wr12_latency: got %0d want 5", cyc); end
    txn(1'b0, 7'h12, cyc);
    for (int k = 0; k < int'(LINE_SIZE); k++) begin
      checks++;
      if (rd_line[k] !== 32'hA000_0000 + 32'(k)) begin
        errors++; $display("FAIL rd12 word %0d: got %h want %h", k, rd_line[k], 32'hA000_0000 + 32'(k));
      end
    end
    txn(1'b0, 7'h13, cyc);
    for (int k = 0; k < int'(LINE_SIZE); k++) begin
      checks++;
      if (rd_line[k] !== 32'(152 + k)) begin
        errors++; $display("FAIL rd13 word %0d: got %h want %h", k, rd_line[k], 32'(152 + k));
      end
    end
  endtask

  task automatic test_back_to_back();
    int total = 0;
    for (int k = 0; k < int'(LINE_SIZE); k++) wr_line[k] = 32'hB000_0000 + 32'(k);
    addr   = 7'h20;
    wr_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      total++;
      if (gnt === 1'b1) break;
    end
    checks++;
    if (total != 5) begin errors++; $display("FAIL b2b_write_gnt: got %0d want 5", total); end
    // Swap-in read raised in response to gnt.
    wr_req = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      total++;
      if (gnt === 1'b1) break;
    end
    checks++;
    if (total != 11) begin errors++; $display("FAIL b2b_read_gnt: got %0d want 11", total); end
    rd_req = 1'b0;
    step();
    checks++;
    if (gnt !== 1'b0) begin errors++; $display("FAIL b2b_gnt_pulse: got %b want 0", gnt); end
    for (int k = 0; k < int'(LINE_SIZE); k++) begin
      checks++;
      if (rd_line[k] !== 32'hB000_0000 + 32'(k)) begin
        errors++; $display("FAIL b2b_hold word %0d: got %h want %h", k, rd_line[k], 32'hB000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_both_req();
    int cyc;
    for (int k = 0; k < int'(LINE_SIZE); k++) wr_line[k] = 32'hC000_0000 + 32'(k);
    addr   = 7'd3;
    wr_req = 1'b1;
    rd_req = 1'b1;
    wait_gnt(cyc);
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL both_write_gnt: got %0d want 5", cyc); end
    checks++;
    if (rd_line[0] !== 32'hB000_0000) begin
      errors++; $display("FAIL both_wr_keeps_rd_line: got %h want b0000000", rd_line[0]);
    end
    wr_req = 1'b0;
    wait_gnt(cyc);
    checks++;
    if (cyc != 6) begin errors++; $display("FAIL both_read_gnt: got %0d want 6", cyc); end
    rd_req = 1'b0;
    for (int k = 0; k < int'(LINE_SIZE); k++) begin
      checks++;
      if (rd_line[k] !== 32'hC000_0000 + 32'(k)) begin
        errors++; $display("FAIL both_rd word %0d: got %h want %h", k, rd_line[k], 32'hC000_0000 + 32'(k));
      end
    end
    step();
  endtask

  task automatic test_abort();
    int cyc;
    int gnt_seen = 0;
    for (int k = 0; k < int'(LINE_SIZE); k++) wr_line[k] = 32'hD000_0000 + 32'(k);
    addr   = 7'h30;
    wr_req = 1'b1;
    step();
    step();
    step();
    wr_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (gnt === 1'b1) gnt_seen++;
    end
    checks++;
    if (gnt_seen != 0) begin errors++; $display("FAIL abort_gnt: got %0d pulses want 0", gnt_seen); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy %b want 0", busy); end
    checks++;
    if (rd_line[5] !== 32'hC000_0005) begin
      errors++; $display("FAIL abort_rd_line: got %h want c0000005", rd_line[5]);
    end
    txn(1'b0, 7'h30, cyc);
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL abort_rd_latency: got %0d want 5", cyc); end
    for (int k = 0; k < int'(LINE_SIZE); k++) begin
      checks++;
      if (rd_line[k] !== 32'(384 + k)) begin
        errors++; $display("FAIL abort_rd word %0d: got %h want %h", k, rd_line[k], 32'(384 + k));
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int n;
    int gnt_seen = 0;
    for (int k = 0; k < int'(LINE_SIZE); k++) wr_line[k] = 32'hE000_0000 + 32'(k);
    addr   = 7'd0;
    wr_req = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst    = 1'b0;
    wr_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b want 1", busy); end
    checks++;
    if (rd_line[3] !== 32'h0) begin errors++; $display("FAIL midrst_rd_line: got %h want 0", rd_line[3]); end
    for (int i = 0; i < 40; i++) begin
      step();
      if (gnt === 1'b1) gnt_seen++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      step();
      n++;
      if (gnt === 1'b1) gnt_seen++;
    end
    checks++;
    if (n != 128) begin errors++; $display("FAIL midinit_restart: got %0d want 128", n); end
    checks++;
    if (gnt_seen != 0) begin errors++; $display("FAIL midrst_gnt: got %0d pulses want 0", gnt_seen); end
    txn(1'b0, 7'd0, cyc);
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL line0_latency: got %0d want 5", cyc); end
    for (int k = 0; k < int'(LINE_SIZE); k++) begin
      checks++;
      if (rd_line[k] !== 32'(k)) begin
        errors++; $display("FAIL line0 word %0d: got %h want %h", k, rd_line[k], 32'(k));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < int'(LINE_SIZE); k++) wr_line[k] = '0;
    test_reset();
    test_init_read();
    test_write_read();
    test_back_to_back();
    test_both_req();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
